uart_cmd_counter: RTL and testbench

Parametrised N-digit BCD up/down counter core with a byte-command front end and a UART status-report back end. It accepts debounced button pulses and received UART bytes as equivalent commands (run/stop, clear, mode) and keeps a decimal count advanced by an internal prescaler. On request it streams the count back as ASCII digits plus CR LF into a TX FIFO push interface. It sits between the UART RX/TX FIFO pair and the FND display controller, replacing the separate command decoder, control unit and fixed 4-digit datapath.

---
 rtl/uart_cmd_counter_if.sv | 12 +
 rtl/uart_cmd_counter.sv | 180 ++++++++++++++++++
 tb/tb_uart_cmd_counter.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_cmd_counter_if.sv
// Byte-stream handshake between uart_cmd_counter and the UART RX/TX FIFO pair.
// master = FIFO side (drives rx bytes and tx_ready), slave = counter core.
interface uart_cmd_counter_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output rx_data, rx_valid, tx_ready, input tx_data, tx_valid);
  modport slave  (input rx_data, rx_valid, tx_ready, output tx_data, tx_valid);
endinterface

// File: rtl/uart_cmd_counter.sv
// N-digit BCD up/down counter driven by buttons or UART command bytes, with an ASCII
// status report streamed to the TX FIFO. Define CMD_ECHO_EN to echo accepted R/C/M bytes.
module uart_cmd_counter #(
  parameter int DIGITS   = 4,
  parameter int TICK_DIV = 10_000_000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                btn_run,
  input  logic                btn_clear,
  input  logic                btn_mode,
  uart_cmd_counter_if.slave   bus,
  output logic [4*DIGITS-1:0] counter,
  output logic                running,
  output logic                mode_down,
  output logic                report_busy
);
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [IW-1:0] IDX_MSB    = IW'(DIGITS - 1);

  typedef enum logic {S_STOP, S_RUN} run_state_t;
`ifdef CMD_ECHO_EN
  typedef enum logic [2:0] {R_IDLE, R_DIG, R_CR, R_LF, R_ECHO} rpt_state_t;
`else
  typedef enum logic [1:0] {R_IDLE, R_DIG, R_CR, R_LF} rpt_state_t;
`endif

  logic rx_run, rx_clr, rx_mode, rx_stat;
  logic cmd_run, cmd_clr, cmd_mode;

  assign rx_run  = bus.rx_valid && (bus.rx_data == "R" || bus.rx_data == "r");
  assign rx_clr  = bus.rx_valid && (bus.rx_data == "C" || bus.rx_data == "c");
  assign rx_mode = bus.rx_valid && (bus.rx_data == "M" || bus.rx_data == "m");
  assign rx_stat = bus.rx_valid && (bus.rx_data == "S" || bus.rx_data == "s");

  // Button and UART sources merge, so a coincident pair acts only once.
  assign cmd_run  = btn_run   | rx_run;
  assign cmd_clr  = btn_clear | rx_clr;
  assign cmd_mode = btn_mode  | rx_mode;

  // ---------------- run/stop FSM ----------------
  run_state_t run_state, run_next;

  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) run_state <= S_STOP;
    else     run_state <= run_next;
  end

  // NOTE: run_next gets its default first, so no path can infer a latch.
  always_comb begin
    run_next = run_state;
    if (cmd_run) run_next = (run_state == S_RUN) ? S_STOP : S_RUN;
  end

  assign running = (run_state == S_RUN);

  // ---------------- prescaler and BCD datapath ----------------
  logic [PW-1:0]       presc;
  logic                tick;
  logic [4*DIGITS-1:0] stepped;

  assign tick = running && (presc == PRESC_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                               presc <= '0;
    else if (cmd_clr || (running && cmd_run)) presc <= '0;
    else if (running)                      presc <= tick ? '0 : presc + PW'(1);
  end

  // Ripple the +1/-1 through the digits; a digit only moves while carry/borrow is live.
  always_comb begin : bcd_step
    logic       carry;
    logic [3:0] dig;
    stepped = counter;
    carry   = 1'b1;
    dig     = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      dig = counter[4*i +: 4];
      if (carry) begin
        if (mode_down) begin
          stepped[4*i +: 4] = (dig == 4'd0) ? 4'd9 : dig - 4'd1;
          carry             = (dig == 4'd0);
        end else begin
          stepped[4*i +: 4] = (dig == 4'd9) ? 4'd0 : dig + 4'd1;
          carry             = (dig == 4'd9);
        end
      end
    end
  end

  // Clear beats a coincident tick; a mode toggle lands after the step it coincides with.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      counter   <= '0;
      mode_down <= 1'b0;
    end else begin
      if (cmd_clr)   counter <= '0;
      else if (tick) counter <= stepped;
      if (cmd_mode)  mode_down <= ~mode_down;
    end
  end

  // ---------------- report / echo FSM ----------------
  rpt_state_t    rpt_state, rpt_next;
  logic [3:0]    snap [DIGITS];
  logic [IW-1:0] dig_idx;
  logic [7:0]    tx_data_c;
  logic          rpt_start;

  assign rpt_start = (rpt_state == R_IDLE) && rx_stat;

`ifdef CMD_ECHO_EN
  logic       rx_echo;
  logic [7:0] echo_byte;

  assign rx_echo = (rpt_state == R_IDLE) && (rx_run || rx_clr || rx_mode);

  always_ff @(posedge clk) begin
    if (rx_echo) echo_byte <= bus.rx_data;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rpt_state <= R_IDLE;
    else     rpt_state <= rpt_next;
  end

  // NOTE: the snapshot has no reset: it is always loaded before R_DIG can read it.
  always_ff @(posedge clk) begin
    if (rpt_start)
      for (int i = 0; i < DIGITS; i++) snap[i] <= counter[4*i +: 4];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                                       dig_idx <= '0;
    else if (rpt_start)                                            dig_idx <= IDX_MSB;
    else if (rpt_state == R_DIG && bus.tx_ready && dig_idx != '0)  dig_idx <= dig_idx - IW'(1);
  end

  always_comb begin
    rpt_next  = rpt_state;
    tx_data_c = 8'h00;
    case (rpt_state)
      R_IDLE: begin
        if (rx_stat) rpt_next = R_DIG;
`ifdef CMD_ECHO_EN
        else if (rx_echo) rpt_next = R_ECHO;
`endif
      end
      R_DIG: begin
        tx_data_c = 8'h30 + {4'h0, snap[dig_idx]};
        if (bus.tx_ready && dig_idx == '0) rpt_next = R_CR;
      end
      R_CR: begin
        tx_data_c = 8'h0D;
        if (bus.tx_ready) rpt_next = R_LF;
      end
      R_LF: begin
        tx_data_c = 8'h0A;
        if (bus.tx_ready) rpt_next = R_IDLE;
      end
`ifdef CMD_ECHO_EN
      R_ECHO: begin
        tx_data_c = echo_byte;
        if (bus.tx_ready) rpt_next = R_IDLE;
      end
`endif
      default: rpt_next = R_IDLE;
    endcase
  end

  // Outputs decode straight from the state, so reset drops tx_valid asynchronously.
  assign report_busy  = (rpt_state != R_IDLE);
  assign bus.tx_valid = report_busy;
  assign bus.tx_data  = tx_data_c;

endmodule

// File: tb/tb_uart_cmd_counter.sv
// Self-checking bench for uart_cmd_counter (DIGITS=4, TICK_DIV=4): an integer/queue
// model checked every cycle, plus directed literal expectations. Honors CMD_ECHO_EN.
module tb_uart_cmd_counter;
  localparam int DIGITS   = 4;
  localparam int TICK_DIV = 4;
  localparam int MODULUS  = 10_000;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                btn_run = 1'b0, btn_clear = 1'b0, btn_mode = 1'b0;
  logic [4*DIGITS-1:0] counter;
  logic                running, mode_down, report_busy;

  uart_cmd_counter_if bus ();

  uart_cmd_counter #(.DIGITS(DIGITS), .TICK_DIV(TICK_DIV)) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_run    (btn_run),
    .btn_clear  (btn_clear),
    .btn_mode   (btn_mode),
    .bus        (bus),
    .counter    (counter),
    .running    (running),
    .mode_down  (mode_down),
    .report_busy(report_busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  function automatic int pow10(input int n);
    int p = 1;
    for (int i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction

  function automatic logic [4*DIGITS-1:0] to_bcd(input int v);
    logic [4*DIGITS-1:0] r = '0;
    for (int i = 0; i < DIGITS; i++) r[4*i +: 4] = 4'((v / pow10(i)) % 10);
    return r;
  endfunction

  // ---------------- behavioural model ----------------
  int         m_count, m_presc;
  bit         m_run, m_down;
  logic [7:0] exp_q [$];
  bit         c_run, c_clr, c_mode, c_stat, m_busy, m_tick;
  logic [7:0] m_b;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_count = 0; m_presc = 0; m_run = 0; m_down = 0;
      exp_q.delete();
    end else begin
      m_b    = bus.rx_data;
      c_run  = btn_run   || (bus.rx_valid && (m_b == "R" || m_b == "r"));
      c_clr  = btn_clear || (bus.rx_valid && (m_b == "C" || m_b == "c"));
      c_mode = btn_mode  || (bus.rx_valid && (m_b == "M" || m_b == "m"));
      c_stat = bus.rx_valid && (m_b == "S" || m_b == "s");
      m_busy = (exp_q.size() != 0);
      m_tick = m_run && (m_presc == TICK_DIV - 1);
      if (m_busy && bus.tx_ready) void'(exp_q.pop_front());
      if (!m_busy && c_stat) begin
        for (int i = DIGITS - 1; i >= 0; i--) exp_q.push_back(8'h30 + 8'((m_count / pow10(i)) % 10));
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
      end
`ifdef CMD_ECHO_EN
      if (!m_busy && bus.rx_valid && (m_b inside {"R", "r", "C", "c", "M", "m"})) exp_q.push_back(m_b);
`endif
      if (c_clr)       m_count = 0;
      else if (m_tick) m_count = m_down ? (m_count + MODULUS - 1) % MODULUS : (m_count + 1) % MODULUS;
      if (c_clr || (m_run && c_run) || m_tick) m_presc = 0;
      else if (m_run)                          m_presc = m_presc + 1;
      if (c_run)  m_run  = !m_run;
      if (c_mode) m_down = !m_down;
    end
  end

  // ---------------- compare and capture ----------------
  logic [7:0] cap_q [$];
  int         hold34 = 0;

  always @(negedge clk) begin
    if (!rst) begin
      check("counter", counter, to_bcd(m_count));
      check("running", running, m_run);
      check("mode_down", mode_down, m_down);
      check("report_busy", report_busy, exp_q.size() != 0);
      check("tx_valid", bus.tx_valid, exp_q.size() != 0);
      if (exp_q.size() != 0) check("tx_data", bus.tx_data, exp_q[0]);
      if (bus.tx_valid && bus.tx_ready) cap_q.push_back(bus.tx_data);
      if (bus.tx_valid && bus.tx_data == 8'h34) hold34++;
    end
  end

  // ---------------- stimulus helpers ----------------
  logic [7:0] rpt_0427 [6] = '{8'h30, 8'h34, 8'h32, 8'h37, 8'h0D, 8'h0A};

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_rx(input logic [7:0] b);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    step();
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (report_busy && n < 50) begin
      step();
      n++;
    end
    check("report_done", report_busy, 1'b0);
  endtask

  task automatic wait_tick_slot();
    int n = 0;
    while (!(m_run && m_presc == TICK_DIV - 1) && n < 20) begin
      step();
      n++;
    end
  endtask

  task automatic check_report(input string name);
    check({name, "_len"}, cap_q.size(), 6);
    for (int i = 0; i < 6; i++)
      check(name, (i < cap_q.size()) ? cap_q[i] : 8'hxx, rpt_0427[i]);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;
    bus.tx_ready = 1'b1;

    step(3);
    check("rst_counter", counter, 16'h0000);
    check("rst_running", running, 1'b0);
    check("rst_mode", mode_down, 1'b0);
    check("rst_tx_valid", bus.tx_valid, 1'b0);
    check("rst_tx_data", bus.tx_data, 8'h00);
    check("rst_busy", report_busy, 1'b0);
    rst = 1'b0;
    step();

    // Run: first step after TICK_DIV cycles, 10 steps after 40.
    send_rx("R");
    check("run_on", running, 1'b1);
    step(4);
    check("first_tick", counter, 16'h0001);
    step(36);
    check("ten_ticks", counter, 16'h0010);
    send_rx("R");
    send_rx("C");
    check("clear", counter, 16'h0000);

    // Down wrap 0000 -> 9999, then up wrap 9999 -> 0000.
    send_rx("M");
    check("mode_down_on", mode_down, 1'b1);
    send_rx("R");
    step(4);
    check("down_wrap", counter, 16'h9999);
    send_rx("R");
    send_rx("M");
    check("mode_up", mode_down, 1'b0);
    send_rx("R");
    step(4);
    check("up_wrap", counter, 16'h0000);
    send_rx("R");

    // Count up to 427 and stop.
    send_rx("R");
    n = 0;
    while (m_count != 427 && n < 3000) begin
      step();
      n++;
    end
    send_rx("R");
    check("at_0427", counter, 16'h0427);
    check("stopped", running, 1'b0);

    // Report with tx_ready always high.
    step(2);
    cap_q.delete();
    send_rx("s");
    wait_idle();
    check_report("rpt_free");

    // Report with stall on the 2nd byte, a clear and a dropped 'S' mid-report.
    step(2);
    cap_q.delete();
    hold34 = 0;
    send_rx("S");
    step();
    bus.tx_ready = 1'b0;
    send_rx("C");
    check("clear_mid_rpt", counter, 16'h0000);
    step(2);
    bus.tx_ready = 1'b1;
    send_rx("S");
    wait_idle();
    step(3);
    check("hold_34", hold34, 4);
    check_report("rpt_stall");
    check("no_second_rpt", report_busy, 1'b0);

    // Button and UART run in the same cycle toggle once.
    bus.rx_data  = "R";
    bus.rx_valid = 1'b1;
    btn_run      = 1'b1;
    step();
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    btn_run      = 1'b0;
    check("run_once", running, 1'b1);

    // Tick coincident with clear: clear wins.
    step(6);
    wait_tick_slot();
    btn_clear = 1'b1;
    step();
    btn_clear = 1'b0;
    check("tick_clear", counter, 16'h0000);

    // Tick coincident with mode toggle: step uses the old (up) mode.
    wait_tick_slot();
    btn_mode = 1'b1;
    step();
    btn_mode = 1'b0;
    check("tick_mode_cnt", counter, 16'h0001);
    check("tick_mode_dir", mode_down, 1'b1);

    // Tick coincident with stop: step still applied.
    wait_tick_slot();
    btn_run = 1'b1;
    step();
    btn_run = 1'b0;
    check("tick_stop_cnt", counter, 16'h0000);
    check("tick_stop_run", running, 1'b0);

    // Unknown byte is ignored; 'm' toggles mode and echoes only when enabled.
    step(2);
    cap_q.delete();
    send_rx("X");
    step(3);
    check("x_no_tx", cap_q.size(), 0);
    check("x_running", running, 1'b0);
    check("x_mode", mode_down, 1'b1);
    send_rx("m");
    step(3);
    check("m_mode", mode_down, 1'b0);
`ifdef CMD_ECHO_EN
    check("echo_len", cap_q.size(), 1);
    check("echo_byte", (cap_q.size() > 0) ? cap_q[0] : 8'hxx, 8'h6D);
`else
    check("no_echo", cap_q.size(), 0);
`endif

    // Reset in the middle of a report.
    send_rx("S");
    step();
    rst = 1'b1;
    #1;
    check("rst_mid_valid", bus.tx_valid, 1'b0);
    check("rst_mid_busy", report_busy, 1'b0);
    step(2);
    rst = 1'b0;
    step(5);
    check("post_rst_busy", report_busy, 1'b0);
    check("post_rst_valid", bus.tx_valid, 1'b0);
    check("post_rst_cnt", counter, 16'h0000);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
